// File: rtl/rng_pkg.sv
// Shared definitions for the RNG consumer blocks: sampler FSM states,
// the reject counter width, and the mask helper for mask-and-reject sampling.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } rng_smp_state_t;

  localparam int REJ_CNT_W = 16;

  // Smallest all-ones mask covering (bound-1); bound 0 means full range.
  function automatic logic [31:0] range_mask(input logic [31:0] bound);
    logic [31:0] m;
    if (bound == 32'd0) begin
      m = '1;
    end else begin
      m = bound - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
    end
    return m;
  endfunction

endpackage

// File: rtl/rng_range_sampler.sv
// Turns a stream of random words into unbiased draws in [0, bound) using
// mask-and-reject sampling; one word is consumed per attempt.
module rng_range_sampler
  import rng_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int BOUND_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    rnd_i,
  input  logic                 rnd_valid_i,
  output logic                 rnd_ready_o,
  input  logic                 req_valid_i,
  input  logic [BOUND_W-1:0]   req_bound_i,
  output logic                 req_ready_o,
  output logic                 smp_valid_o,
  output logic [BOUND_W-1:0]   smp_o,
  input  logic                 smp_ready_i,
  output logic [REJ_CNT_W-1:0] reject_cnt_o
);

  rng_smp_state_t r_state;
  rng_smp_state_t w_stateNext;

  logic [BOUND_W-1:0]   r_bound;
  logic [BOUND_W-1:0]   r_mask;
  logic [BOUND_W-1:0]   r_smp;
  logic [REJ_CNT_W-1:0] r_rejCnt;

  logic [31:0]        w_maskFull;
  logic [BOUND_W-1:0] w_cand;
  logic               w_accept;
  logic               w_reqFire;
  logic               w_wordFire;
  logic               w_unused;

  assign w_maskFull = range_mask(32'(req_bound_i));
  assign w_cand     = rnd_i[BOUND_W-1:0] & r_mask;
  assign w_accept   = (r_bound == '0) || (w_cand < r_bound);
  assign w_reqFire  = req_valid_i && (r_state == IDLE);
  assign w_wordFire = rnd_valid_i && (r_state == DRAW);

  // Upper word bits carry no information for a BOUND_W-wide draw.
  assign w_unused = ^{rnd_i[WORD_W-1:BOUND_W], w_maskFull[31:BOUND_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    rnd_ready_o = 1'b0;
    req_ready_o = 1'b0;
    smp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_stateNext = DRAW;
      end
      DRAW: begin
        rnd_ready_o = 1'b1;
        if (rnd_valid_i && w_accept) w_stateNext = HOLD;
      end
      HOLD: begin
        smp_valid_o = 1'b1;
        if (smp_ready_i) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bound  <= '0;
      r_mask   <= '0;
      r_smp    <= '0;
      r_rejCnt <= '0;
    end else begin
      if (w_reqFire) begin
        r_bound <= req_bound_i;
        r_mask  <= w_maskFull[BOUND_W-1:0];
      end
      if (w_wordFire) begin
        if (w_accept) begin
          r_smp <= w_cand;
        end else if (r_rejCnt != '1) begin
          r_rejCnt <= r_rejCnt + 1'b1;
        end
      end
    end
  end

  assign smp_o        = r_smp;
  assign reject_cnt_o = r_rejCnt;

endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed bench for rng_range_sampler: an arithmetic reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_rng_range_sampler;

  logic        clk;
  logic        rst;
  logic [31:0] rnd_i;
  logic        rnd_valid_i;
  logic        rnd_ready_o;
  logic        req_valid_i;
  logic [15:0] req_bound_i;
  logic        req_ready_o;
  logic        smp_valid_o;
  logic [15:0] smp_o;
  logic        smp_ready_i;
  logic [15:0] reject_cnt_o;

  int total = 0;
  int bad   = 0;

  rng_range_sampler #(.WORD_W(32), .BOUND_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_i        (rnd_i),
    .rnd_valid_i  (rnd_valid_i),
    .rnd_ready_o  (rnd_ready_o),
    .req_valid_i  (req_valid_i),
    .req_bound_i  (req_bound_i),
    .req_ready_o  (req_ready_o),
    .smp_valid_o  (smp_valid_o),
    .smp_o        (smp_o),
    .smp_ready_i  (smp_ready_i),
    .reject_cnt_o (reject_cnt_o)
  );

  // 10 time-unit clock; inputs change 1 unit after the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 waits for a request, 1 draws, 2 holds a sample.
  // The candidate is the low 16 bits reduced modulo the next power of two.
  int mPhase;
  int mBound;
  int mSmp;
  int mRej;

  function automatic int drawRange(input int bound);
    int p;
    if (bound == 0) return 65536;
    p = 1;
    while (p < bound) p = p * 2;
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0;
      mBound = 0;
      mSmp   = 0;
      mRej   = 0;
    end else begin
      case (mPhase)
        0: if (req_valid_i) begin
          mBound = int'(req_bound_i);
          mPhase = 1;
        end
        1: if (rnd_valid_i) begin
          int cand;
          cand = int'(rnd_i[15:0]) % drawRange(mBound);
          if (mBound == 0 || cand < mBound) begin
            mSmp   = cand;
            mPhase = 2;
          end else if (mRej < 65535) begin
            mRej = mRej + 1;
          end
        end
        default: if (smp_ready_i) mPhase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready_o), 32'(mPhase == 0));
    checkOutput("rnd_ready", 32'(rnd_ready_o), 32'(mPhase == 1));
    checkOutput("smp_valid", 32'(smp_valid_o), 32'(mPhase == 2));
    checkOutput("smp_value", 32'(smp_o), 32'(mSmp));
    checkOutput("reject_cnt", 32'(reject_cnt_o), 32'(mRej));
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] bound);
    req_valid_i = 1'b1;
    req_bound_i = bound;
    stepEdge();
    req_valid_i = 1'b0;
    req_bound_i = 16'h5A5A;
  endtask

  task automatic feedWord(input logic [31:0] w);
    rnd_valid_i = 1'b1;
    rnd_i       = w;
    stepEdge();
    rnd_valid_i = 1'b0;
    rnd_i       = 32'hDEAD_BEEF;
  endtask

  task automatic takeSample();
    smp_ready_i = 1'b1;
    stepEdge();
    smp_ready_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rnd_i       = '0;
    rnd_valid_i = 1'b0;
    req_valid_i = 1'b0;
    req_bound_i = '0;
    smp_ready_i = 1'b0;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("reset_rnd_ready", 32'(rnd_ready_o), 32'd0);
    checkOutput("reset_smp_valid", 32'(smp_valid_o), 32'd0);
    checkOutput("reset_smp", 32'(smp_o), 32'd0);
    checkOutput("reset_rej", 32'(reject_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stepEdge();

    // bound 10, word 7: sample two cycles after the request edge.
    applyStimulus(16'd10);
    checkOutput("b10_draw_rnd_ready", 32'(rnd_ready_o), 32'd1);
    feedWord(32'h0000_0007);
    checkOutput("b10_smp_valid", 32'(smp_valid_o), 32'd1);
    checkOutput("b10_smp", 32'(smp_o), 32'd7);
    checkOutput("b10_rej", 32'(reject_cnt_o), 32'd0);
    takeSample();
    checkOutput("b10_back_idle", 32'(req_ready_o), 32'd1);

    // bound 10: 0xC rejected, 0x3 accepted.
    applyStimulus(16'd10);
    feedWord(32'h0000_000C);
    checkOutput("b10rej_still_draw", 32'(smp_valid_o), 32'd0);
    feedWord(32'h0000_0003);
    checkOutput("b10rej_smp", 32'(smp_o), 32'd3);
    checkOutput("b10rej_rej", 32'(reject_cnt_o), 32'd1);
    takeSample();

    // bound 0 is full range; bound 1 always yields 0.
    applyStimulus(16'd0);
    feedWord(32'hABCD_1234);
    checkOutput("b0_smp", 32'(smp_o), 32'h1234);
    takeSample();
    applyStimulus(16'd1);
    feedWord(32'hFFFF_FFFF);
    checkOutput("b1_smp", 32'(smp_o), 32'd0);
    checkOutput("b1_valid", 32'(smp_valid_o), 32'd1);

    // Hold the sample with back-pressure while upstream keeps offering data.
    rnd_valid_i = 1'b1;
    rnd_i       = 32'h0000_0009;
    req_valid_i = 1'b1;
    req_bound_i = 16'd3;
    repeat (5) begin
      stepEdge();
      checkOutput("hold_valid", 32'(smp_valid_o), 32'd1);
      checkOutput("hold_smp", 32'(smp_o), 32'd0);
      checkOutput("hold_rnd_ready", 32'(rnd_ready_o), 32'd0);
      checkOutput("hold_req_ready", 32'(req_ready_o), 32'd0);
    end
    rnd_valid_i = 1'b0;
    req_valid_i = 1'b0;
    takeSample();
    checkOutput("release_idle", 32'(req_ready_o), 32'd1);
    checkOutput("release_valid", 32'(smp_valid_o), 32'd0);

    // Reset in DRAW after three rejections.
    applyStimulus(16'd10);
    repeat (3) feedWord(32'h0000_000E);
    checkOutput("pre_rst_rej", 32'(reject_cnt_o), 32'd4);
    rst = 1'b1;
    #1;
    checkOutput("rst_rnd_ready", 32'(rnd_ready_o), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_smp_valid", 32'(smp_valid_o), 32'd0);
    checkOutput("rst_smp", 32'(smp_o), 32'd0);
    checkOutput("rst_rej", 32'(reject_cnt_o), 32'd0);
    #1 rst = 1'b0;
    stepEdge();
    applyStimulus(16'd10);
    feedWord(32'h0000_0005);
    checkOutput("post_rst_smp", 32'(smp_o), 32'd5);
    checkOutput("post_rst_rej", 32'(reject_cnt_o), 32'd0);
    takeSample();

    // Saturate the reject counter with bound 17 and 0x1F words.
    applyStimulus(16'd17);
    rnd_valid_i = 1'b1;
    rnd_i       = 32'h0000_001F;
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat_near", 32'(reject_cnt_o), 32'hFFFE);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("sat_full", 32'(reject_cnt_o), 32'hFFFF);
    checkOutput("sat_still_draw", 32'(rnd_ready_o), 32'd1);
    rnd_valid_i = 1'b0;
    feedWord(32'h0000_0004);
    checkOutput("sat_smp", 32'(smp_o), 32'd4);
    checkOutput("sat_rej_hold", 32'(reject_cnt_o), 32'hFFFF);
    takeSample();
    stepEdge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_range_sampler.md
# rng_range_sampler

Consumer-side block for the RNG cores: accepts 32-bit random words over a valid/ready stream and turns them into uniformly distributed integers in [0, bound) for downstream stochastic logic. Each request carries its own bound. Unbiased output uses mask-and-reject sampling: each attempt consumes exactly one word, and out-of-range candidates are discarded. Sits between an RNG core (e.g. taus88_core) and any client needing bounded draws.

## Interface
- WORD_W, 32: width of incoming random words
- BOUND_W, 16: width of bound and sample; must be ≤ WORD_W
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rnd_i  in  WORD_W  random word from the RNG core
- rnd_valid_i  in  1  rnd_i valid
- rnd_ready_o  out  1  word consumed on a cycle where rnd_valid_i && rnd_ready_o
- req_valid_i  in  1  sample request
- req_bound_i  in  BOUND_W  exclusive upper bound; 0 means full range 2^BOUND_W
- req_ready_o  out  1  request accepted on req_valid_i && req_ready_o
- smp_valid_o  out  1  sample valid
- smp_o  out  BOUND_W  sample value
- smp_ready_i  in  1  downstream accepts the sample
- reject_cnt_o  out  16  cumulative rejected candidates, saturating

## Operation
- FSM states: IDLE, DRAW, HOLD. Reset state is IDLE.
- Reset values: rnd_ready_o=0, req_ready_o=1, smp_valid_o=0, smp_o=0, reject_cnt_o=0. Internal bound and mask registers also reset to 0.
- IDLE
  - req_ready_o=1.
  - On handshake: latch bound_q=req_bound_i and mask_q, then go to DRAW.
  - mask_q when bound≠0: all bits at and below the MSB of (bound−1). Examples: bound 1 → 0x0000, bound 10 → 0x000F, bound 16 → 0x000F, bound 17 → 0x001F.
  - mask_q when bound=0: all ones.
- DRAW
  - rnd_ready_o=1, req_ready_o=0.
  - On word handshake: cand = rnd_i[BOUND_W-1:0] & mask_q.
  - Accept if bound_q=0 or cand < bound_q: smp_o←cand, go to HOLD.
  - Otherwise: reject_cnt_o increments (saturates at 0xFFFF) and the FSM stays in DRAW.
  - Rejection probability per attempt is below 1/2, so no retry cap is applied.
- HOLD
  - smp_valid_o=1; rnd_ready_o=0 and req_ready_o=0.
  - smp_o stays stable until the handshake.
  - On smp_ready_i: go to IDLE and drop smp_valid_o the next cycle.
- Bits rnd_i[WORD_W-1:BOUND_W] are ignored.
- bound=1 always yields 0 and still consumes one word.
- req_bound_i is ignored outside IDLE; changing it mid-operation has no effect.
- Reset asserted in any state: aborts the draw, discards the pending sample and clears reject_cnt_o. Outputs take reset values immediately (asynchronous).
- reject_cnt_o is never cleared except by rst.

## Timing
- Request handshake at edge N puts the FSM in DRAW during cycle N+1.
- If a word is valid in N+1 and accepted: smp_valid_o is high in cycle N+2. Minimum latency is 2 cycles from request to sample.
- Each rejection adds one cycle. Each cycle with rnd_valid_i=0 in DRAW adds one cycle.
- Sample handshake at edge M puts the FSM in IDLE in cycle M+1. The next request can be accepted in M+1, giving one request per 3 cycles at best.
- All outputs are registered or decoded from the FSM state only. There are no combinational paths from any input to any output.
- Asserting rnd_valid_i while rnd_ready_o=0 is legal; the word is simply not consumed.

## Structure
- Shared package rng_pkg:
  - state enum rng_smp_state_t {IDLE, DRAW, HOLD};
  - function range_mask(bound) returning the mask above (pure combinational, reusable by other samplers);
  - localparam REJ_CNT_W=16.
- Single module. No sub-module; mask generation is the package function.

## Test plan
- bound=10, rnd_i=0x0000_0007 → smp_o=7 two cycles after the request handshake; reject_cnt_o=0.
- bound=10, words 0x0000_000C then 0x0000_0003 → first word rejected, smp_o=3, reject_cnt_o=1, latency 3 cycles.
- bound=0, rnd_i=0xABCD_1234 → smp_o=0x1234. bound=1, rnd_i=0xFFFF_FFFF → smp_o=0.
- smp_ready_i low for 5 cycles in HOLD → smp_valid_o and smp_o stable, rnd_ready_o=0, req_ready_o=0; release → IDLE next cycle.
- rst asserted mid-DRAW after 3 rejections → all outputs at reset values immediately, reject_cnt_o=0; a fresh request after release works normally.
- Force 0x1_0005 rejections (bound=17, feed 0x1F repeatedly) → reject_cnt_o saturates at 0xFFFF; a later 0x04 yields smp_o=4.
